// File: rtl/rv_tx_arbiter.sv
// rv_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// valid/ready transmit channel. The winning word is registered, held until the
// sink accepts it, and then tx_done pulses for one cycle.
// Optional feature macro: RV_ARB_TIMEOUT_EN. When defined, a SEND-state
// watchdog drops a word that has waited TIMEOUT cycles and sets err_timeout.
//
// state | meaning
// IDLE  | searching for a requester; req_ready strobes the winner
// SEND  | out_valid high, word held until out_ready
// DONE  | handshake complete, tx_done high for this one cycle
module rv_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_data_Tx,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDW-1:0]            out_id,
    output logic                      tx_done,
    output logic                      err_timeout
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t              state;
    logic [IDW-1:0]      last_grant;
    logic [IDW-1:0]      winner;
    logic [DATA_W-1:0]   win_data;
    logic                found;
    logic                grant;
    int                  scan_idx;
    logic                timeout_hit;

`ifdef RV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] send_cnt;
    logic             err_q;

    // Word is abandoned on the edge that completes the TIMEOUT-th stalled SEND cycle.
    assign timeout_hit = (send_cnt == CNT_W'(TIMEOUT - 1)) && !out_ready;
    assign err_timeout = err_q;
`else
    logic unused_timeout;

    // Watchdog compiled out: SEND waits indefinitely for the sink.
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // Rotating-priority search starting just after last_grant; one-hot strobe in IDLE only.
    always_comb begin
        winner    = '0;
        win_data  = '0;
        found     = 1'b0;
        scan_idx  = 0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found    = 1'b1;
                winner   = IDW'(scan_idx);
                win_data = req_data[scan_idx*DATA_W +: DATA_W];
            end
        end
        grant = (state == IDLE) && en_data_Tx && found;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Transfer FSM with registered channel outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            tx_done    <= 1'b0;
            last_grant <= IDW'(NUM_REQ - 1);
`ifdef RV_ARB_TIMEOUT_EN
            send_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_done <= 1'b0;
                    if (grant) begin
                        out_data   <= win_data;
                        out_id     <= winner;
                        last_grant <= winner;
                        out_valid  <= 1'b1;
                        state      <= SEND;
`ifdef RV_ARB_TIMEOUT_EN
                        send_cnt   <= '0;
`endif
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        tx_done   <= 1'b1;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef RV_ARB_TIMEOUT_EN
                        err_q     <= 1'b1;
`endif
                    end
`ifdef RV_ARB_TIMEOUT_EN
                    else begin
                        send_cnt <= send_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    tx_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    tx_done   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_tx_arbiter.sv
// Bench for rv_tx_arbiter: directed stimulus pushes expected {id, data} words
// into a scoreboard; a negedge monitor pops and compares on each handshake,
// checks word stability while stalled and the tx_done pulse after handshake.
module tb_rv_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int IDW     = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      en_data_Tx;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [IDW-1:0]            out_id;
    logic                      tx_done;
    logic                      err_timeout;

    int checks   = 0;
    int failures = 0;

    logic [IDW+DATA_W-1:0] sb[$];
    logic [DATA_W-1:0]     dat[NUM_REQ];

    logic                  expect_done = 1'b0;
    logic                  stalled     = 1'b0;
    logic [DATA_W-1:0]     hold_data;
    logic [IDW-1:0]        hold_id;

    rv_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDW(IDW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .en_data_Tx(en_data_Tx),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .tx_done(tx_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant strobe and compare it against the expected one-hot.
    task automatic wait_grant(input logic [NUM_REQ-1:0] exp);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        check("req_ready", DATA_W'(req_ready), DATA_W'(exp));
    endtask

    // Monitor: pops the scoreboard on every handshake and checks the follow-up pulse.
    always @(negedge clk) begin
        if (!reset) begin
            expect_done = 1'b0;
            stalled     = 1'b0;
        end else begin
            if (expect_done) begin
                check("tx_done_pulse", DATA_W'({tx_done, out_valid}), DATA_W'(2'b10));
                expect_done = 1'b0;
            end else if (tx_done) begin
                check("spurious_tx_done", DATA_W'(tx_done), '0);
            end
            if (out_valid) begin
                if (stalled) begin
                    check("stable_data", out_data, hold_data);
                    check("stable_id", DATA_W'(out_id), DATA_W'(hold_id));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", DATA_W'(out_id), '1);
                    end else begin
                        logic [IDW+DATA_W-1:0] e;
                        e = sb.pop_front();
                        check("out_id", DATA_W'(out_id), DATA_W'(e[IDW+DATA_W-1:DATA_W]));
                        check("out_data", out_data, e[DATA_W-1:0]);
                    end
                    expect_done = 1'b1;
                    stalled     = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    hold_data = out_data;
                    hold_id   = out_id;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        dat[0] = 64'hDEADBEEFCAFEBABE;
        dat[1] = 64'h0123456789ABCDEF;
        dat[2] = 64'hA5A5A5A55A5A5A5A;
        dat[3] = 64'hFEDCBA9876543210;
        req_data   = {dat[3], dat[2], dat[1], dat[0]};
        reset      = 1'b0;
        en_data_Tx = 1'b1;
        req_valid  = '0;
        out_ready  = 1'b0;
        #12;
        check("rst_out_valid", DATA_W'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_id", DATA_W'(out_id), '0);
        check("rst_tx_done", DATA_W'(tx_done), '0);
        check("rst_err", DATA_W'(err_timeout), '0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // 1: single requester 0, sink always ready
        req_valid = 4'b0001;
        out_ready = 1'b1;
        sb.push_back({2'd0, dat[0]});
        wait_grant(4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();

        // 2: all requesting from reset pointer -> 0,1,2,3,0
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({IDW'(i % 4), dat[i % 4]});
        end
        for (int i = 0; i < 5; i++) begin
            wait_grant(NUM_REQ'(1) << (i % 4));
            step();
        end
        req_valid = '0;
        repeat (4) step();

        // 3: req 2 captured, sink stalls 5 cycles
        out_ready = 1'b0;
        req_valid = 4'b0100;
        sb.push_back({2'd2, dat[2]});
        wait_grant(4'b0100);
        step();
        req_valid = '0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", DATA_W'(out_valid), 1);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();

        // 4: enable low blocks grants; re-enable -> req 1 wins (pointer at 2)
        en_data_Tx = 1'b0;
        req_valid  = 4'b0110;
        repeat (3) begin
            @(negedge clk);
            check("en0_req_ready", DATA_W'(req_ready), '0);
            check("en0_out_valid", DATA_W'(out_valid), '0);
            step();
        end
        en_data_Tx = 1'b1;
        sb.push_back({2'd1, dat[1]});
        wait_grant(4'b0010);
        step();
        req_valid = '0;
        repeat (4) step();

        // 5: reset mid-SEND discards the word; req 0 wins afterwards
        out_ready = 1'b0;
        req_valid = 4'b1000;
        wait_grant(4'b1000);
        step();
        req_valid = '0;
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_send_valid", DATA_W'(out_valid), '0);
        check("rst_mid_send_id", DATA_W'(out_id), '0);
        @(negedge clk); reset = 1'b1;
        step();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        sb.push_back({2'd0, dat[0]});
        wait_grant(4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();

        // 6: watchdog (TIMEOUT=8) or indefinite wait without the macro
        out_ready = 1'b0;
        req_valid = 4'b0010;
`ifndef RV_ARB_TIMEOUT_EN
        sb.push_back({2'd1, dat[1]});
`endif
        wait_grant(4'b0010);
        step();
        req_valid = '0;
        repeat (12) step();
        @(negedge clk);
`ifdef RV_ARB_TIMEOUT_EN
        check("timeout_err", DATA_W'(err_timeout), 1);
        check("timeout_valid", DATA_W'(out_valid), '0);
`else
        check("timeout_err", DATA_W'(err_timeout), '0);
        check("timeout_valid", DATA_W'(out_valid), 1);
`endif
        step();
        out_ready = 1'b1;
        repeat (4) step();

        for (int n = 0; n < 50 && sb.size() != 0; n++) step();
        check("sb_empty", DATA_W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
